pipelined_add_sub: RTL and testbench
====================================

Name: pipelined_add_sub

Overview:
- Parametrised, pipelined signed fixed-point adder/subtractor for the ODE solver datapath.
- The carry chain is split into SEG_WIDTH-bit lookahead segments, with one segment per pipeline stage and the carry registered between stages.
- Adds per-operation add/sub select, optional saturation, a carry flag, a sideband tag, and valid/ready backpressure.
- Sustains one operation per cycle.

Parameters:
- DATA_WIDTH, 16: operand/result width in bits; must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 4: bits resolved per pipeline stage; must be a multiple of 4.
- TAG_WIDTH, 4: sideband tag width, carried unchanged alongside the data.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- in_a  in  DATA_WIDTH  signed operand A.
- in_b  in  DATA_WIDTH  signed operand B.
- in_op  in  1  0 = A+B, 1 = A-B.
- in_sat  in  1  1 = saturate on signed overflow.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_WIDTH  result (wrapped or saturated).
- out_overflow  out  1  signed overflow occurred (set even when saturated).
- out_carry  out  1  raw carry out of the MSB; for subtract, 1 = no borrow.
- out_tag  out  TAG_WIDTH  tag of this result.

Behaviour:
- STAGES = DATA_WIDTH/SEG_WIDTH.
- Latency: exactly STAGES cycles from input acceptance to out_valid when there is no stall.
- Accept: an input is accepted when in_valid && in_ready are both high at a clock edge.
- Stall: the stall condition is out_valid && !out_ready.
  - While stalled, every stage holds its contents.
  - in_ready = !stall, combinational.
  - Bubbles are not compressed during a stall.
- Transfer: a result transfers on out_valid && out_ready. Results leave in acceptance order with no loss or duplication.
- Operand conditioning (at capture): Beff = in_op ? ~in_b : in_b; cin = in_op.
- Stage k (0..STAGES-1):
  - Adds segment k of A and Beff using the registered carry from stage k-1 (cin for k=0).
  - Registers the segment sum, carry out, and the A/Beff bits still pending.
  - Lower result segments are skewed forward through the pipeline.
  - op, sat, tag and valid travel with the data.
- Final stage:
  - ovf = (A[msb] == Beff[msb]) && (sum[msb] != A[msb]).
  - If sat && ovf: result = A[msb] ? 1 followed by zeros (most negative) : 0 followed by ones (most positive).
  - Otherwise result = raw sum (two's-complement wrap).
  - out_carry = carry out of the MSB segment, independent of sat.
- Reset (asserted at any time, including mid-stream):
  - All stage valid bits clear immediately; in-flight operations are discarded.
  - out_valid=0, out_result=0, out_overflow=0, out_carry=0, out_tag=0.
  - in_ready=1 after reset.
- Invalid stage contents are don't-care internally; outputs still show the last valid result or the reset value.
- Boundary cases:
  - A - most-negative: handled through Beff; overflow detection is correct (0 - 0x8000 overflows).
  - Simultaneous accept and output transfer while not stalled: both occur in the same cycle.
  - in_valid with in_ready low: no capture; the upstream holds its data.

Decomposition:
- Shared package holds:
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Helper functions for max-positive and max-negative saturation constants from DATA_WIDTH.
  - STAGES derivation.
- Sub-module cla_segment:
  - SEG_WIDTH-bit combinational lookahead adder (a, b, cin -> sum, cout), built as chained 4-bit propagate/generate groups.
  - One instance per pipeline stage via generate.

Test Plan:
- Add, no overflow: 0x1234 + 0x0FED, op=0, sat=0 -> 0x2221, ovf=0, carry=0, out_valid exactly 4 cycles after accept.
- Add overflow: 0x7FFF + 0x0001 with sat=0 -> 0x8000, ovf=1. Same with sat=1 -> 0x7FFF, ovf=1.
- Subtract edges, sat=1:
  - 0x0000 - 0x8000 -> 0x7FFF, ovf=1.
  - 0x8000 - 0x0001 -> 0x8000, ovf=1.
  - 0x0005 - 0x0003 -> 0x0002, ovf=0, carry=1.
- Backpressure: stream 8 back-to-back ops with tags 0..7, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, all 8 results in tag order, values correct, none duplicated.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight -> outputs are zero immediately and none of those ops ever appears; the next accepted op after release returns with 4-cycle latency.
- Configuration sweep: DATA_WIDTH=32, SEG_WIDTH=8, 10k random ops with random op, sat and out_ready -> every result matches the reference model; latency 4 cycles when unstalled.

Source files
------------

// File: rtl/pipelined_add_sub_pkg.sv
// Shared constants and helpers for the segmented pipelined adder/subtractor.
package pipelined_add_sub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int calc_stages(input int dw, input int sw);
      return dw / sw;
   endfunction

   function automatic logic [127:0] sat_pos(input int dw);
      return (128'd1 << (dw - 1)) - 128'd1;
   endfunction

   function automatic logic [127:0] sat_neg(input int dw);
      return 128'd1 << (dw - 1);
   endfunction

endpackage

// File: rtl/pipelined_add_sub_cla_segment.sv
// Combinational lookahead adder for one segment, built from 4-bit P/G groups.
module cla_segment #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int GROUPS = WIDTH / 4;

   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] c;
   logic [3:0]       gp;
   logic [3:0]       gg;
   logic             grp_p;
   logic             grp_g;
   logic             cg;

   assign p = a ^ b;
   assign g = a & b;

   // Carries inside a group come straight from cg; only cg chains groups.
   always_comb begin
      c     = '0;
      gp    = '0;
      gg    = '0;
      grp_p = 1'b0;
      grp_g = 1'b0;
      cg    = cin;
      for (int j = 0; j < GROUPS; j++) begin
         gp = p[4*j +: 4];
         gg = g[4*j +: 4];
         c[4*j]   = cg;
         c[4*j+1] = gg[0] | (gp[0] & cg);
         c[4*j+2] = gg[1] | (gp[1] & gg[0])
                  | (gp[1] & gp[0] & cg);
         c[4*j+3] = gg[2] | (gp[2] & gg[1])
                  | (gp[2] & gp[1] & gg[0])
                  | (gp[2] & gp[1] & gp[0] & cg);
         grp_g = gg[3] | (gp[3] & gg[2])
               | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]);
         grp_p = &gp;
         cg = grp_g | (grp_p & cg);
      end
   end

   assign sum  = p ^ c;
   assign cout = cg;

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined signed add/sub: one carry-lookahead segment per stage,
// carry registered between stages, optional saturation, valid/ready.
module pipelined_add_sub
   import pipelined_add_sub_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int SEG_WIDTH  = 4,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic                  in_op,
   input  logic                  in_sat,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic                  out_overflow,
   output logic                  out_carry,
   output logic [TAG_WIDTH-1:0]  out_tag
);

   localparam int STAGES = calc_stages(DATA_WIDTH, SEG_WIDTH);
   localparam logic [DATA_WIDTH-1:0] MAX_POS =
      DATA_WIDTH'(sat_pos(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] MAX_NEG =
      DATA_WIDTH'(sat_neg(DATA_WIDTH));

   typedef struct packed {
      logic                 valid;
      logic                 sat;
      logic [TAG_WIDTH-1:0] tag;
   } ctrl_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] result;
      logic                  ovf;
      logic                  carry;
      logic [TAG_WIDTH-1:0]  tag;
   } res_t;

   logic                  stall;
   logic [DATA_WIDTH-1:0] beff;
   logic                  cin;
   ctrl_t                 in_ctl;
   res_t                  out_q;
   res_t                  out_d;
   logic                  out_vld_q;
   logic                  out_vld_d;

   assign stall    = out_vld_q & ~out_ready;
   assign in_ready = ~stall;

   always_comb begin
      beff = in_b;
      cin  = 1'b0;
      unique case (in_op)
         OP_ADD: begin
            beff = in_b;
            cin  = 1'b0;
         end
         OP_SUB: begin
            beff = ~in_b;
            cin  = 1'b1;
         end
      endcase
   end

   assign in_ctl = ctrl_t'{valid: in_valid,
                           sat:   in_sat,
                           tag:   in_tag};

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int REM  = DATA_WIDTH - k * SEG_WIDTH;
      localparam int DONE = (k + 1) * SEG_WIDTH;

      logic [REM-1:0]       src_a;
      logic [REM-1:0]       src_b;
      logic                 src_c;
      ctrl_t                src_ctl;
      logic [SEG_WIDTH-1:0] seg_s;
      logic                 seg_co;
      logic [DONE-1:0]      acc;

      if (k == 0) begin : g_head
         assign src_a   = in_a;
         assign src_b   = beff;
         assign src_c   = cin;
         assign src_ctl = in_ctl;
         assign acc     = seg_s;
      end else begin : g_tail
         assign src_a   = g_stg[k-1].g_mid.a_q;
         assign src_b   = g_stg[k-1].g_mid.b_q;
         assign src_c   = g_stg[k-1].g_mid.c_q;
         assign src_ctl = g_stg[k-1].g_mid.ctl_q;
         assign acc     = {seg_s, g_stg[k-1].g_mid.s_q};
      end

      cla_segment #(
         .WIDTH (SEG_WIDTH)
      ) u_cla (
         .a    (src_a[SEG_WIDTH-1:0]),
         .b    (src_b[SEG_WIDTH-1:0]),
         .cin  (src_c),
         .sum  (seg_s),
         .cout (seg_co)
      );

      if (k < STAGES - 1) begin : g_mid
         // Only the operand bits above this segment travel on.
         logic [REM-SEG_WIDTH-1:0] a_q;
         logic [REM-SEG_WIDTH-1:0] a_d;
         logic [REM-SEG_WIDTH-1:0] b_q;
         logic [REM-SEG_WIDTH-1:0] b_d;
         logic [DONE-1:0]          s_q;
         logic [DONE-1:0]          s_d;
         logic                     c_q;
         logic                     c_d;
         ctrl_t                    ctl_q;
         ctrl_t                    ctl_d;

         always_comb begin
            a_d   = a_q;
            b_d   = b_q;
            s_d   = s_q;
            c_d   = c_q;
            ctl_d = ctl_q;
            if (!stall) begin
               ctl_d.valid = src_ctl.valid;
               if (src_ctl.valid) begin
                  ctl_d = src_ctl;
                  a_d   = src_a[REM-1:SEG_WIDTH];
                  b_d   = src_b[REM-1:SEG_WIDTH];
                  s_d   = acc;
                  c_d   = seg_co;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q   <= '0;
               b_q   <= '0;
               s_q   <= '0;
               c_q   <= 1'b0;
               ctl_q <= '0;
            end else begin
               a_q   <= a_d;
               b_q   <= b_d;
               s_q   <= s_d;
               c_q   <= c_d;
               ctl_q <= ctl_d;
            end
         end
      end else begin : g_last
         logic sgn_a;
         logic ovf;

         assign sgn_a = src_a[REM-1];
         assign ovf   = (sgn_a == src_b[REM-1])
                      && (acc[DATA_WIDTH-1] != sgn_a);

         // Data only loads with a valid op so outputs keep the last result.
         always_comb begin
            out_d     = out_q;
            out_vld_d = out_vld_q;
            if (!stall) begin
               out_vld_d = src_ctl.valid;
               if (src_ctl.valid) begin
                  out_d.result = (src_ctl.sat && ovf)
                               ? (sgn_a ? MAX_NEG : MAX_POS)
                               : acc;
                  out_d.ovf    = ovf;
                  out_d.carry  = seg_co;
                  out_d.tag    = src_ctl.tag;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               out_q     <= '0;
               out_vld_q <= 1'b0;
            end else begin
               out_q     <= out_d;
               out_vld_q <= out_vld_d;
            end
         end
      end
   end

   assign out_valid    = out_vld_q;
   assign out_result   = out_q.result;
   assign out_overflow = out_q.ovf;
   assign out_carry    = out_q.carry;
   assign out_tag      = out_q.tag;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed edges on a 16/4 instance,
// random traffic on a 32/8 instance, both against an arithmetic model.
module tb_pipelined_add_sub;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // 16-bit, 4-bit segment instance
   logic        s_rst_n, s_in_valid, s_in_ready, s_in_op, s_in_sat;
   logic        s_out_valid, s_out_ready, s_out_ovf, s_out_carry;
   logic [15:0] s_in_a, s_in_b, s_out_result;
   logic [3:0]  s_in_tag, s_out_tag;

   // 32-bit, 8-bit segment instance
   logic        w_rst_n, w_in_valid, w_in_ready, w_in_op, w_in_sat;
   logic        w_out_valid, w_out_ready, w_out_ovf, w_out_carry;
   logic [31:0] w_in_a, w_in_b, w_out_result;
   logic [3:0]  w_in_tag, w_out_tag;

   pipelined_add_sub #(
      .DATA_WIDTH (16),
      .SEG_WIDTH  (4),
      .TAG_WIDTH  (4)
   ) u_s (
      .clk          (clk),
      .rst_n        (s_rst_n),
      .in_valid     (s_in_valid),
      .in_ready     (s_in_ready),
      .in_a         (s_in_a),
      .in_b         (s_in_b),
      .in_op        (s_in_op),
      .in_sat       (s_in_sat),
      .in_tag       (s_in_tag),
      .out_valid    (s_out_valid),
      .out_ready    (s_out_ready),
      .out_result   (s_out_result),
      .out_overflow (s_out_ovf),
      .out_carry    (s_out_carry),
      .out_tag      (s_out_tag)
   );

   pipelined_add_sub #(
      .DATA_WIDTH (32),
      .SEG_WIDTH  (8),
      .TAG_WIDTH  (4)
   ) u_w (
      .clk          (clk),
      .rst_n        (w_rst_n),
      .in_valid     (w_in_valid),
      .in_ready     (w_in_ready),
      .in_a         (w_in_a),
      .in_b         (w_in_b),
      .in_op        (w_in_op),
      .in_sat       (w_in_sat),
      .in_tag       (w_in_tag),
      .out_valid    (w_out_valid),
      .out_ready    (w_out_ready),
      .out_result   (w_out_result),
      .out_overflow (w_out_ovf),
      .out_carry    (w_out_carry),
      .out_tag      (w_out_tag)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Signed arithmetic on integers, then range test / clamp / wrap.
   function automatic void ref_model(input int w,
                                     input logic [63:0] a,
                                     input logic [63:0] b,
                                     input logic op,
                                     input logic sat,
                                     output logic [63:0] res,
                                     output logic ovf,
                                     output logic carry);
      longint half, sa, sb, raw;
      logic [63:0] mask, ua, ub;
      half = longint'(1) << (w - 1);
      mask = 64'((half << 1) - 1);
      ua = a & mask;
      ub = b & mask;
      sa = longint'(ua);
      sb = longint'(ub);
      if (sa >= half) sa = sa - 2 * half;
      if (sb >= half) sb = sb - 2 * half;
      raw = op ? sa - sb : sa + sb;
      ovf = (raw > half - 1) || (raw < -half);
      if (sat && ovf) raw = (raw < 0) ? -half : half - 1;
      res = 64'(raw) & mask;
      if (op) carry = (ua >= ub);
      else    carry = ((ua + ub) >> w) != 0;
   endfunction

   task automatic s_single(input string nm,
                           input logic [15:0] a,
                           input logic [15:0] b,
                           input logic op,
                           input logic sat,
                           input logic [3:0] tg,
                           input logic [15:0] er,
                           input logic eo,
                           input logic ec);
      int n;
      @(negedge clk);
      s_in_a = a;
      s_in_b = b;
      s_in_op = op;
      s_in_sat = sat;
      s_in_tag = tg;
      s_in_valid = 1'b1;
      s_out_ready = 1'b1;
      #1;
      check({nm, "_rdy"}, s_in_ready, 1);
      @(negedge clk);
      s_in_valid = 1'b0;
      n = 1;
      while (!s_out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_lat"}, n, 4);
      check({nm, "_res"}, s_out_result, er);
      check({nm, "_ovf"}, s_out_ovf, eo);
      check({nm, "_cy"}, s_out_carry, ec);
      check({nm, "_tag"}, s_out_tag, tg);
      @(negedge clk);
   endtask

   task automatic s_backpressure();
      logic [15:0] va[8], vb[8];
      logic        vo[8], vs[8];
      logic [63:0] er[8];
      logic        eo[8], ec[8];
      int          got;
      for (int i = 0; i < 8; i++) begin
         va[i] = 16'($urandom);
         vb[i] = 16'($urandom);
         vo[i] = 1'($urandom);
         vs[i] = 1'($urandom);
         ref_model(16, 64'(va[i]), 64'(vb[i]), vo[i], vs[i],
                   er[i], eo[i], ec[i]);
      end
      got = 0;
      fork
         begin
            int tries;
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               s_in_valid = 1'b1;
               s_in_a = va[i];
               s_in_b = vb[i];
               s_in_op = vo[i];
               s_in_sat = vs[i];
               s_in_tag = 4'(i);
               #1;
               tries = 0;
               while (!s_in_ready && tries < 20) begin
                  @(negedge clk);
                  #1;
                  tries++;
               end
            end
            @(negedge clk);
            s_in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 40; c++) begin
               @(negedge clk);
               s_out_ready = !(c >= 5 && c < 8);
               #1;
               check("bp_in_ready", s_in_ready,
                     !(s_out_valid && !s_out_ready));
               if (s_out_valid && s_out_ready) begin
                  if (got < 8) begin
                     check("bp_tag", s_out_tag, 4'(got));
                     check("bp_res", s_out_result, er[got]);
                     check("bp_ovf", s_out_ovf, eo[got]);
                     check("bp_cy", s_out_carry, ec[got]);
                  end else begin
                     check("bp_extra", s_out_valid, 0);
                  end
                  got++;
               end
            end
         end
      join
      check("bp_count", got, 8);
      s_out_ready = 1'b1;
   endtask

   task automatic s_reset_mid();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         s_in_valid = 1'b1;
         s_in_a = 16'h0100 + 16'(i);
         s_in_b = 16'h0010;
         s_in_op = 1'b0;
         s_in_sat = 1'b0;
         s_in_tag = 4'(9 + i);
         s_out_ready = 1'b1;
      end
      @(negedge clk);
      s_in_valid = 1'b0;
      s_rst_n = 1'b0;
      #1;
      check("rst_valid", s_out_valid, 0);
      check("rst_res", s_out_result, 0);
      check("rst_ovf", s_out_ovf, 0);
      check("rst_cy", s_out_carry, 0);
      check("rst_tag", s_out_tag, 0);
      check("rst_ready", s_in_ready, 1);
      repeat (2) @(negedge clk);
      s_rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("rst_no_ghost", s_out_valid, 0);
      end
      s_single("post_rst", 16'h4000, 16'h4000, 1'b0, 1'b1,
               4'hC, 16'h7FFF, 1'b1, 1'b0);
   endtask

   typedef struct {
      int          t;
      logic [31:0] res;
      logic        ovf;
      logic        carry;
      logic [3:0]  tag;
   } exp_t;

   task automatic w_random();
      exp_t        q[$];
      exp_t        e;
      logic [63:0] r;
      logic        ro, rc, stall, pending, seen;
      int          cyc, last_stall, accepted;
      cyc = 0;
      last_stall = -1;
      accepted = 0;
      pending = 1'b0;
      seen = 1'b0;
      for (int it = 0; it < 40000; it++) begin
         if (accepted >= 10000 && q.size() == 0) break;
         @(negedge clk);
         cyc++;
         if (!pending) begin
            if (accepted < 10000) begin
               w_in_valid = ($urandom_range(3) != 0);
               w_in_a = $urandom;
               w_in_b = $urandom;
               w_in_op = 1'($urandom);
               w_in_sat = 1'($urandom);
               w_in_tag = 4'($urandom);
            end else begin
               w_in_valid = 1'b0;
            end
         end
         w_out_ready = (accepted >= 10000) ||
                       ($urandom_range(3) != 0);
         #1;
         stall = w_out_valid && !w_out_ready;
         check("w_in_ready", w_in_ready, !stall);
         if (w_out_valid) begin
            if (q.size() == 0) begin
               check("w_spurious", w_out_valid, 0);
            end else begin
               if (!seen) begin
                  seen = 1'b1;
                  if (last_stall < q[0].t)
                     check("w_lat", cyc - q[0].t, 4);
               end
               if (w_out_ready) begin
                  e = q.pop_front();
                  check("w_res", w_out_result, e.res);
                  check("w_ovf", w_out_ovf, e.ovf);
                  check("w_cy", w_out_carry, e.carry);
                  check("w_tag", w_out_tag, e.tag);
                  seen = 1'b0;
               end
            end
         end
         if (stall) last_stall = cyc;
         if (w_in_valid && w_in_ready) begin
            ref_model(32, 64'(w_in_a), 64'(w_in_b),
                      w_in_op, w_in_sat, r, ro, rc);
            e.t = cyc;
            e.res = r[31:0];
            e.ovf = ro;
            e.carry = rc;
            e.tag = w_in_tag;
            q.push_back(e);
            accepted++;
            pending = 1'b0;
         end else begin
            pending = w_in_valid;
         end
      end
      check("w_accepted", accepted, 10000);
      check("w_drained", q.size(), 0);
   endtask

   initial begin
      s_rst_n = 1'b0;
      w_rst_n = 1'b0;
      s_in_valid = 1'b0;
      s_in_a = '0;
      s_in_b = '0;
      s_in_op = 1'b0;
      s_in_sat = 1'b0;
      s_in_tag = '0;
      s_out_ready = 1'b1;
      w_in_valid = 1'b0;
      w_in_a = '0;
      w_in_b = '0;
      w_in_op = 1'b0;
      w_in_sat = 1'b0;
      w_in_tag = '0;
      w_out_ready = 1'b1;
      #1;
      check("init_valid", s_out_valid, 0);
      check("init_res", s_out_result, 0);
      check("init_ready", s_in_ready, 1);
      check("init_w_valid", w_out_valid, 0);
      repeat (2) @(negedge clk);
      s_rst_n = 1'b1;
      w_rst_n = 1'b1;

      s_single("add", 16'h1234, 16'h0FED, 1'b0, 1'b0,
               4'h1, 16'h2221, 1'b0, 1'b0);
      s_single("add_wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
               4'h2, 16'h8000, 1'b1, 1'b0);
      s_single("add_sat", 16'h7FFF, 16'h0001, 1'b0, 1'b1,
               4'h3, 16'h7FFF, 1'b1, 1'b0);
      s_single("sub_minneg", 16'h0000, 16'h8000, 1'b1, 1'b1,
               4'h4, 16'h7FFF, 1'b1, 1'b0);
      s_single("sub_neg_sat", 16'h8000, 16'h0001, 1'b1, 1'b1,
               4'h5, 16'h8000, 1'b1, 1'b1);
      s_single("sub_small", 16'h0005, 16'h0003, 1'b1, 1'b1,
               4'h6, 16'h0002, 1'b0, 1'b1);

      s_backpressure();
      s_reset_mid();
      w_random();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
